// File: rtl/glitch_pkg.sv
// Shared definitions for the glitch-generator trigger path.
package glitch_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t ARMED   = 2'd1;
    localparam state_t FIRE    = 2'd2;
    localparam state_t HOLDOFF = 2'd3;

    localparam int unsigned CLK_HZ = 204_000_000;

endpackage

// File: rtl/trigger_qualifier_if.sv
// Control/status bundle between the trigger qualifier and its controller.
interface trigger_qualifier_if;
    logic        trigger_in;
    logic        arm;
    logic        disarm;
    logic        trig_out;
    logic        armed_indicator;
    logic        holdoff_indicator;
    logic [15:0] edge_count;

    modport master (
        output trigger_in, arm, disarm,
        input  trig_out, armed_indicator, holdoff_indicator, edge_count
    );

    modport slave (
        input  trigger_in, arm, disarm,
        output trig_out, armed_indicator, holdoff_indicator, edge_count
    );
endinterface

// File: rtl/trigger_filter.sv
// Synchronises the raw trigger pin and rejects levels shorter than FILTER_COUNT cycles.
module trigger_filter #(
    parameter int unsigned FILTER_COUNT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam logic [16:0] FilterLim = 17'(FILTER_COUNT);

    logic        sync1_q, sync2_q;
    logic        filt_q, filt_d;
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] cnt_inc;

    assign cnt_inc = {1'b0, cnt_q} + 17'd1;

    // Accept on the cycle the count would reach the limit, so a level held for
    // exactly FILTER_COUNT cycles is taken without an extra cycle of delay.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync2_q != filt_q) begin
            if (cnt_inc == FilterLim) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_inc[15:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout = filt_q;
endmodule

// File: rtl/trigger_qualifier.sv
// Turns a filtered trigger level into a single-cycle fire pulse on the Nth
// qualified edge while armed, followed by a holdoff period.
module trigger_qualifier
    import glitch_pkg::*;
#(
    parameter int unsigned FILTER_COUNT  = 8,
    parameter int unsigned TRIG_NTH      = 1,
    parameter logic [31:0] HOLDOFF_COUNT = 32'(CLK_HZ),
    parameter bit          RISING        = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    trigger_qualifier_if.slave  bus
);
    localparam logic [15:0] NthLim = 16'(TRIG_NTH);

    logic        filt;
    logic        filt_prev_q;
    logic        qual_edge;
    state_t      state_q, state_d;
    logic [15:0] ec_q, ec_d, ec_inc;
    logic [31:0] hcnt_q, hcnt_d;
    logic        trig_q, armed_q, hold_q;

    trigger_filter #(
        .FILTER_COUNT (FILTER_COUNT)
    ) u_filter (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.trigger_in),
        .dout (filt)
    );

    assign qual_edge = RISING ? (filt & ~filt_prev_q) : (~filt & filt_prev_q);
    assign ec_inc    = (ec_q == 16'hFFFF) ? ec_q : ec_q + 16'd1;

    always_comb begin
        state_d = state_q;
        ec_d    = ec_q;
        hcnt_d  = hcnt_q;
        case (state_q)
            IDLE: begin
                if (bus.arm) begin
                    state_d = ARMED;
                    ec_d    = '0;
                end
            end
            ARMED: begin
                if (qual_edge) begin
                    ec_d = ec_inc;
                    if (ec_inc == NthLim) state_d = FIRE;
                end
            end
            FIRE: begin
                hcnt_d  = '0;
                state_d = HOLDOFF;
            end
            HOLDOFF: begin
                if (hcnt_q == HOLDOFF_COUNT) begin
                    state_d = ARMED;
                    ec_d    = '0;
                end else begin
                    hcnt_d = hcnt_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Disarm overrides everything, including a simultaneous arm.
        if (bus.disarm) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_prev_q <= 1'b0;
            state_q     <= IDLE;
            ec_q        <= '0;
            hcnt_q      <= '0;
            trig_q      <= 1'b0;
            armed_q     <= 1'b0;
            hold_q      <= 1'b0;
        end else begin
            filt_prev_q <= filt;
            state_q     <= state_d;
            ec_q        <= ec_d;
            hcnt_q      <= hcnt_d;
            // A FIRE already entered still emits its pulse even if disarmed.
            trig_q      <= (state_q == FIRE);
            armed_q     <= (state_q == ARMED);
            hold_q      <= (state_q == HOLDOFF);
        end
    end

    assign bus.trig_out          = trig_q;
    assign bus.armed_indicator   = armed_q;
    assign bus.holdoff_indicator = hold_q;
    assign bus.edge_count        = ec_q;
endmodule

// File: tb/tb_trigger_qualifier.sv
// Scoreboard bench: a pulse-level reference model predicts fire cycles; monitors compare.
module tb_trigger_qualifier;
    localparam int F  = 4;
    localparam int N1 = 3;
    localparam int H1 = 100;

    logic clk = 1'b0;
    logic rst1 = 1'b1;
    logic rst2 = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp1[$];
    int   exp2[$];
    int   ho_run = 0;
    int   ho_last = 0;

    // Reference model state for the first instance
    bit   m_armed = 1'b0;
    int   m_arm_edge = 0;
    int   m_rearm_edge = 0;
    int   m_count = 0;

    trigger_qualifier_if q1 ();
    trigger_qualifier_if q2 ();

    trigger_qualifier #(
        .FILTER_COUNT (F),
        .TRIG_NTH     (N1),
        .HOLDOFF_COUNT(32'(H1)),
        .RISING       (1'b1)
    ) u_dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (q1)
    );

    trigger_qualifier #(
        .FILTER_COUNT (F),
        .TRIG_NTH     (1),
        .HOLDOFF_COUNT(32'd0),
        .RISING       (1'b0)
    ) u_dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (q2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A rise driven during cycle n is qualified if its high run lasts >= F cycles;
    // the FSM acts on it at edge n+F+3 and trig_out shows in cycle n+F+4.
    task automatic m_edge(input int n);
        int a;
        a = n + F + 3;
        if (m_armed && (a - 1) >= m_arm_edge && (a - 1) >= m_rearm_edge) begin
            if (m_count < 65535) m_count++;
            if (m_count == N1) begin
                exp1.push_back(a + 1);
                m_rearm_edge = a + H1 + 2;
                m_count      = 0;
            end
        end
    endtask

    task automatic p1(input int w, input int g);
        q1.trigger_in = 1'b1;
        if (w >= F) m_edge(cyc);
        tick(w);
        q1.trigger_in = 1'b0;
        tick(g);
    endtask

    task automatic arm1();
        q1.arm     = 1'b1;
        m_armed    = 1'b1;
        m_arm_edge = cyc + 1;
        m_count    = 0;
        tick(1);
        q1.arm = 1'b0;
        tick(1);
    endtask

    task automatic disarm1();
        q1.disarm = 1'b1;
        m_armed   = 1'b0;
        tick(1);
        q1.disarm = 1'b0;
        tick(1);
    endtask

    always @(negedge clk) begin
        if (q1.trig_out) begin
            chk("dut1_fire_expected", longint'(exp1.size() > 0), 1);
            if (exp1.size() > 0) begin
                chk("dut1_fire_cycle", cyc, exp1.pop_front());
                chk("dut1_fire_edge_count", q1.edge_count, N1);
            end
        end
        if (q2.trig_out) begin
            chk("dut2_fire_expected", longint'(exp2.size() > 0), 1);
            if (exp2.size() > 0) begin
                chk("dut2_fire_cycle", cyc, exp2.pop_front());
                chk("dut2_fire_edge_count", q2.edge_count, 1);
            end
        end
    end

    always @(negedge clk) begin
        if (q1.holdoff_indicator) begin
            ho_run <= ho_run + 1;
        end else begin
            if (ho_run != 0) ho_last <= ho_run;
            ho_run <= 0;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 60000", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        q1.trigger_in = 1'b0; q1.arm = 1'b0; q1.disarm = 1'b0;
        q2.trigger_in = 1'b0; q2.arm = 1'b0; q2.disarm = 1'b0;
        #22;
        rst1 = 1'b0;
        rst2 = 1'b0;
        tick(2);

        chk("reset_trig_out", q1.trig_out, 0);
        chk("reset_armed", q1.armed_indicator, 0);
        chk("reset_holdoff", q1.holdoff_indicator, 0);
        chk("reset_edge_count", q1.edge_count, 0);

        // Edges while idle are ignored
        for (int i = 0; i < 5; i++) p1(20, 20);
        chk("idle_edge_count", q1.edge_count, 0);
        chk("idle_armed", q1.armed_indicator, 0);

        arm1();
        chk("armed_indicator", q1.armed_indicator, 1);
        p1(20, 20);
        chk("edge_count_step1", q1.edge_count, 1);
        p1(20, 20);
        chk("edge_count_step2", q1.edge_count, 2);
        p1(20, 20);
        tick(90);
        chk("holdoff_length", ho_last, H1 + 1);
        chk("rearm_armed", q1.armed_indicator, 1);
        chk("rearm_edge_count", q1.edge_count, 0);

        // Short glitches rejected, a pulse of exactly F cycles accepted
        for (int i = 0; i < 10; i++) p1(F - 1, 10);
        chk("glitch_edge_count", q1.edge_count, 0);
        p1(F, 10);
        chk("min_pulse_edge_count", q1.edge_count, 1);

        // Fire, then edges inside holdoff must not count
        p1(5, 5);
        p1(5, 5);
        for (int i = 0; i < 5; i++) p1(5, 5);
        tick(120);
        chk("holdoff_ignore_edge_count", q1.edge_count, 0);
        chk("holdoff_ignore_armed", q1.armed_indicator, 1);
        for (int i = 0; i < 3; i++) p1(20, 20);
        tick(130);

        disarm1();
        chk("disarm_armed", q1.armed_indicator, 0);
        q1.arm = 1'b1; q1.disarm = 1'b1;
        tick(1);
        q1.arm = 1'b0; q1.disarm = 1'b0;
        tick(3);
        chk("arm_disarm_same_cycle", q1.armed_indicator, 0);

        arm1();
        for (int i = 0; i < 3; i++) p1(10, 10);
        chk("holdoff_active", q1.holdoff_indicator, 1);
        disarm1();
        chk("disarm_in_holdoff_ind", q1.holdoff_indicator, 0);
        chk("disarm_in_holdoff_armed", q1.armed_indicator, 0);
        tick(130);

        // Randomised pulse train against the model
        arm1();
        for (int i = 0; i < 40; i++) p1(int'($urandom_range(1, 12)), int'($urandom_range(F, 40)));
        tick(250);
        disarm1();
        chk("dut1_pending_fires", exp1.size(), 0);

        // Falling-edge instance: N=1, zero holdoff
        q2.arm = 1'b1;
        tick(1);
        q2.arm = 1'b0;
        tick(1);
        q2.trigger_in = 1'b1;
        tick(20);
        chk("fall_rise_no_count", q2.edge_count, 0);
        q2.trigger_in = 1'b0;
        exp2.push_back(cyc + F + 4);
        tick(20);
        chk("fall_rearm_armed", q2.armed_indicator, 1);
        chk("fall_rearm_edge_count", q2.edge_count, 0);

        // Reset while a fire is in the pipeline: the fire is lost
        q2.trigger_in = 1'b1;
        tick(20);
        q2.trigger_in = 1'b0;
        n = cyc;
        tick(5);
        #2 rst2 = 1'b1;
        #1;
        chk("rst_async_trig_out", q2.trig_out, 0);
        chk("rst_async_armed", q2.armed_indicator, 0);
        chk("rst_async_holdoff", q2.holdoff_indicator, 0);
        chk("rst_async_edge_count", q2.edge_count, 0);
        tick(3);
        #3 rst2 = 1'b0;
        tick(30);
        chk("post_rst_idle", q2.armed_indicator, 0);
        chk("dut2_pending_fires", exp2.size(), 0);
        chk("rst_drop_was_pending", longint'(cyc > n + F + 4), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
